hazard_fwd_ctrl: RTL and testbench

Pipeline hazard and forwarding controller for the 5-stage pipelined processor. It tracks the destination and source registers of the instructions in EX, MEM and WB in a shadow pipeline and drives the 2-bit select lines of the EX-stage operand forwarding muxes. It detects load-use hazards and raises a stall, and squashes the decode-stage instruction on a taken branch. It also counts stall cycles for performance reporting.

---
 rtl/hazard_fwd_ctrl_if.sv | 36 +++
 rtl/hazard_fwd_ctrl.sv | 128 ++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_fwd_ctrl_if.sv
// rtl/hazard_fwd_ctrl_if.sv - decode-side hazard/forwarding bus between pipeline and hazard_fwd_ctrl
//
// Ports (signals):
//   id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread : decode-stage instruction
//   br_taken                                                  : branch in EX resolved taken
//   stall_out, flush_out                                      : pipeline hold / IF-ID squash
//   fwd_a_sel, fwd_b_sel                                      : EX operand mux selects
//   stall_cnt                                                 : saturating stall cycle count
// master = pipeline side, slave = hazard_fwd_ctrl.
interface hazard_fwd_ctrl_if #(
    parameter int RAW  = 5,
    parameter int CNTW = 16
);
    logic            id_valid;
    logic [RAW-1:0]  id_rs1;
    logic [RAW-1:0]  id_rs2;
    logic [RAW-1:0]  id_rd;
    logic            id_regwrite;
    logic            id_memread;
    logic            br_taken;
    logic            stall_out;
    logic            flush_out;
    logic [1:0]      fwd_a_sel;
    logic [1:0]      fwd_b_sel;
    logic [CNTW-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread, br_taken,
        input  stall_out, flush_out, fwd_a_sel, fwd_b_sel, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread, br_taken,
        output stall_out, flush_out, fwd_a_sel, fwd_b_sel, stall_cnt
    );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// rtl/hazard_fwd_ctrl.sv - load-use stall, branch flush and EX operand forwarding control
//
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset, clears shadow pipeline and stall counter
//   bus  : hazard_fwd_ctrl_if.slave (decode instruction in, stall/flush/fwd selects/stall_cnt out)
// Outputs other than stall_cnt are combinational from the shadow stages and same-cycle inputs.
module hazard_fwd_ctrl #(
    parameter int RAW  = 5,
    parameter int CNTW = 16
) (
    input  logic              clk,
    input  logic              rst,
    hazard_fwd_ctrl_if.slave  bus
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    // EX keeps everything hazard detection needs; MEM and WB only ever act
    // as forwarding producers, so they keep just valid/rd/regwrite.
    logic           ex_valid;
    logic           ex_regwrite;
    logic           ex_memread;
    logic [RAW-1:0] ex_rd;
    logic [RAW-1:0] ex_rs1;
    logic [RAW-1:0] ex_rs2;

    logic           mem_valid;
    logic           mem_regwrite;
    logic [RAW-1:0] mem_rd;

    logic           wb_valid;
    logic           wb_regwrite;
    logic [RAW-1:0] wb_rd;

    logic [CNTW-1:0] cnt;

    logic stall;
    logic flush;
    logic bubble;
    logic load_hit;
    logic mem_hit_a;
    logic mem_hit_b;
    logic wb_hit_a;
    logic wb_hit_b;

    // A stage produces r only if it really writes a non-zero register r.
    function automatic logic writes(input logic v, input logic rw,
                                    input logic [RAW-1:0] rd, input logic [RAW-1:0] r);
        return v && rw && (rd != '0) && (rd == r);
    endfunction

    assign mem_hit_a = writes(mem_valid, mem_regwrite, mem_rd, ex_rs1);
    assign mem_hit_b = writes(mem_valid, mem_regwrite, mem_rd, ex_rs2);
    assign wb_hit_a  = writes(wb_valid,  wb_regwrite,  wb_rd,  ex_rs1);
    assign wb_hit_b  = writes(wb_valid,  wb_regwrite,  wb_rd,  ex_rs2);

    // Load in EX whose result the decode instruction needs next cycle.
    assign load_hit = ex_valid && ex_memread && ex_regwrite && (ex_rd != '0) &&
                      ((ex_rd == bus.id_rs1) || (ex_rd == bus.id_rs2));

    // A taken branch squashes the decode instruction, so stalling it is moot.
    assign flush  = bus.br_taken;
    assign stall  = bus.id_valid && load_hit && !bus.br_taken;
    assign bubble = flush || stall || !bus.id_valid;

    always_comb begin
        bus.fwd_a_sel = SEL_RF;
        bus.fwd_b_sel = SEL_RF;
        if (ex_valid) begin
            // MEM is the younger producer, so it wins over WB.
            if (mem_hit_a)     bus.fwd_a_sel = SEL_MEM;
            else if (wb_hit_a) bus.fwd_a_sel = SEL_WB;
            if (mem_hit_b)     bus.fwd_b_sel = SEL_MEM;
            else if (wb_hit_b) bus.fwd_b_sel = SEL_WB;
        end
    end

    assign bus.stall_out = stall;
    assign bus.flush_out = flush;
    assign bus.stall_cnt = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_regwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            ex_rd        <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            mem_valid    <= 1'b0;
            mem_regwrite <= 1'b0;
            mem_rd       <= '0;
            wb_valid     <= 1'b0;
            wb_regwrite  <= 1'b0;
            wb_rd        <= '0;
            cnt          <= '0;
        end else begin
            wb_valid     <= mem_valid;
            wb_regwrite  <= mem_regwrite;
            wb_rd        <= mem_rd;
            mem_valid    <= ex_valid;
            mem_regwrite <= ex_regwrite;
            mem_rd       <= ex_rd;
            if (bubble) begin
                ex_valid    <= 1'b0;
                ex_regwrite <= 1'b0;
                ex_memread  <= 1'b0;
                ex_rd       <= '0;
                ex_rs1      <= '0;
                ex_rs2      <= '0;
            end else begin
                ex_valid    <= 1'b1;
                ex_regwrite <= bus.id_regwrite;
                ex_memread  <= bus.id_memread;
                ex_rd       <= bus.id_rd;
                ex_rs1      <= bus.id_rs1;
                ex_rs2      <= bus.id_rs2;
            end
            if (stall && (cnt != {CNTW{1'b1}})) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb/tb_hazard_fwd_ctrl.sv - scoreboard testbench for hazard_fwd_ctrl
module tb_hazard_fwd_ctrl;
    localparam int RAW  = 5;
    // Narrow counter so saturation is reachable quickly (stalls come at most every other cycle).
    localparam int CNTW = 10;
    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_fwd_ctrl_if #(.RAW(RAW), .CNTW(CNTW)) bus ();
    hazard_fwd_ctrl #(.RAW(RAW), .CNTW(CNTW)) dut (.clk(clk), .rst(rst), .bus(bus));

    // One row = one decode cycle: inputs plus expected {stall, flush, fwd_a, fwd_b}.
    typedef struct {
        logic       rst;
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic       br;
        logic [5:0] exp;
    } row_t;

    typedef struct {
        string      name;
        logic [5:0] v;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic row_t mk(input logic r, input logic v, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd, input logic rw,
                                input logic mr, input logic br, input logic [5:0] exp);
        row_t x;
        x.rst = r; x.v = v; x.rs1 = rs1; x.rs2 = rs2; x.rd = rd;
        x.rw = rw; x.mr = mr; x.br = br; x.exp = exp;
        return x;
    endfunction

    function automatic row_t nop(input logic [5:0] exp);
        return mk(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, exp);
    endfunction

    function automatic row_t alu(input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [5:0] exp);
        return mk(1'b0, 1'b1, rs1, rs2, rd, 1'b1, 1'b0, 1'b0, exp);
    endfunction

    function automatic row_t ld(input logic [4:0] rd, input logic [4:0] rs1, input logic [5:0] exp);
        return mk(1'b0, 1'b1, rs1, 5'd0, rd, 1'b1, 1'b1, 1'b0, exp);
    endfunction

    // Drive one row at the falling edge and queue what the DUT must show this cycle.
    task automatic apply(input string name, input row_t x);
        exp_t e;
        @(negedge clk);
        rst             = x.rst;
        bus.id_valid    = x.v;
        bus.id_rs1      = x.rs1;
        bus.id_rs2      = x.rs2;
        bus.id_rd       = x.rd;
        bus.id_regwrite = x.rw;
        bus.id_memread  = x.mr;
        bus.br_taken    = x.br;
        e.name = name;
        e.v    = x.exp;
        sb.push_back(e);
    endtask

    task automatic test_reset;
        row_t rows[$];
        exp_t e;
        logic [5:0] got;
        rows.push_back(mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 6'b01_00_00));
        rows.push_back(mk(1'b1, 1'b1, 5'd1, 5'd1, 5'd1, 1'b1, 1'b1, 1'b0, 6'b00_00_00));
        rows.push_back(nop(6'b00_00_00));
        rows.push_back(nop(6'b00_00_00));
        foreach (rows[i]) begin
            apply($sformatf("reset[%0d]", i), rows[i]);
            #2;
            e = sb.pop_front();
            got = {bus.stall_out, bus.flush_out, bus.fwd_a_sel, bus.fwd_b_sel};
            checks++;
            if (got !== e.v) begin
                errors++;
                $display("FAIL %s: stall/flush/a/b got %b required %b", e.name, got, e.v);
            end
        end
        checks++;
        if (bus.stall_cnt !== '0) begin
            errors++;
            $display("FAIL reset_cnt: stall_cnt got %0d required 0", bus.stall_cnt);
        end
    endtask

    task automatic test_alu_b2b;
        row_t rows[$];
        exp_t e;
        logic [5:0] got;
        rows.push_back(alu(5'd3, 5'd1, 5'd2, 6'b00_00_00));
        rows.push_back(alu(5'd4, 5'd3, 5'd3, 6'b00_00_00));
        rows.push_back(nop(6'b00_01_01));
        rows.push_back(nop(6'b00_00_00));
        foreach (rows[i]) begin
            apply($sformatf("alu_b2b[%0d]", i), rows[i]);
            #2;
            e = sb.pop_front();
            got = {bus.stall_out, bus.flush_out, bus.fwd_a_sel, bus.fwd_b_sel};
            checks++;
            if (got !== e.v) begin
                errors++;
                $display("FAIL %s: stall/flush/a/b got %b required %b", e.name, got, e.v);
            end
        end
    endtask

    task automatic test_distance;
        row_t rows[$];
        exp_t e;
        logic [5:0] got;
        // MEM and WB both write r5: MEM wins.
        rows.push_back(alu(5'd5, 5'd1, 5'd2, 6'b00_00_00));
        rows.push_back(alu(5'd5, 5'd1, 5'd2, 6'b00_00_00));
        rows.push_back(alu(5'd8, 5'd5, 5'd6, 6'b00_00_00));
        rows.push_back(nop(6'b00_01_00));
        // Distance 2 through a NOP: WB forward.
        rows.push_back(alu(5'd5, 5'd1, 5'd2, 6'b00_00_00));
        rows.push_back(nop(6'b00_00_00));
        rows.push_back(alu(5'd8, 5'd6, 5'd5, 6'b00_00_00));
        rows.push_back(nop(6'b00_00_10));
        // Distance 3: register file covers it.
        rows.push_back(alu(5'd5, 5'd1, 5'd2, 6'b00_00_00));
        rows.push_back(nop(6'b00_00_00));
        rows.push_back(nop(6'b00_00_00));
        rows.push_back(alu(5'd8, 5'd5, 5'd5, 6'b00_00_00));
        rows.push_back(nop(6'b00_00_00));
        foreach (rows[i]) begin
            apply($sformatf("distance[%0d]", i), rows[i]);
            #2;
            e = sb.pop_front();
            got = {bus.stall_out, bus.flush_out, bus.fwd_a_sel, bus.fwd_b_sel};
            checks++;
            if (got !== e.v) begin
                errors++;
                $display("FAIL %s: stall/flush/a/b got %b required %b", e.name, got, e.v);
            end
        end
    endtask

    task automatic test_load_use;
        row_t rows[$];
        exp_t e;
        logic [5:0] got;
        rows.push_back(ld(5'd7, 5'd1, 6'b00_00_00));
        rows.push_back(alu(5'd9, 5'd1, 5'd7, 6'b10_00_00));
        rows.push_back(alu(5'd9, 5'd1, 5'd7, 6'b00_00_00));
        rows.push_back(nop(6'b00_00_10));
        rows.push_back(nop(6'b00_00_00));
        foreach (rows[i]) begin
            apply($sformatf("load_use[%0d]", i), rows[i]);
            #2;
            e = sb.pop_front();
            got = {bus.stall_out, bus.flush_out, bus.fwd_a_sel, bus.fwd_b_sel};
            checks++;
            if (got !== e.v) begin
                errors++;
                $display("FAIL %s: stall/flush/a/b got %b required %b", e.name, got, e.v);
            end
        end
        checks++;
        if (bus.stall_cnt !== 1) begin
            errors++;
            $display("FAIL load_use_cnt: stall_cnt got %0d required 1", bus.stall_cnt);
        end
    endtask

    task automatic test_reg_zero;
        row_t rows[$];
        exp_t e;
        logic [5:0] got;
        rows.push_back(alu(5'd0, 5'd1, 5'd2, 6'b00_00_00));
        rows.push_back(alu(5'd0, 5'd0, 5'd0, 6'b00_00_00));
        rows.push_back(ld(5'd0, 5'd0, 6'b00_00_00));
        rows.push_back(alu(5'd10, 5'd0, 5'd0, 6'b00_00_00));
        rows.push_back(nop(6'b00_00_00));
        rows.push_back(nop(6'b00_00_00));
        foreach (rows[i]) begin
            apply($sformatf("reg_zero[%0d]", i), rows[i]);
            #2;
            e = sb.pop_front();
            got = {bus.stall_out, bus.flush_out, bus.fwd_a_sel, bus.fwd_b_sel};
            checks++;
            if (got !== e.v) begin
                errors++;
                $display("FAIL %s: stall/flush/a/b got %b required %b", e.name, got, e.v);
            end
        end
        checks++;
        if (bus.stall_cnt !== 1) begin
            errors++;
            $display("FAIL reg_zero_cnt: stall_cnt got %0d required 1", bus.stall_cnt);
        end
    endtask

    task automatic test_flush_vs_stall;
        row_t rows[$];
        exp_t e;
        logic [5:0] got;
        rows.push_back(ld(5'd7, 5'd1, 6'b00_00_00));
        rows.push_back(mk(1'b0, 1'b1, 5'd1, 5'd7, 5'd9, 1'b1, 1'b0, 1'b1, 6'b01_00_00));
        // Had the flushed consumer entered EX, MEM (the load) would forward 01 here.
        rows.push_back(nop(6'b00_00_00));
        rows.push_back(nop(6'b00_00_00));
        foreach (rows[i]) begin
            apply($sformatf("flush_stall[%0d]", i), rows[i]);
            #2;
            e = sb.pop_front();
            got = {bus.stall_out, bus.flush_out, bus.fwd_a_sel, bus.fwd_b_sel};
            checks++;
            if (got !== e.v) begin
                errors++;
                $display("FAIL %s: stall/flush/a/b got %b required %b", e.name, got, e.v);
            end
        end
        checks++;
        if (bus.stall_cnt !== 1) begin
            errors++;
            $display("FAIL flush_stall_cnt: stall_cnt got %0d required 1", bus.stall_cnt);
        end
    endtask

    task automatic test_reset_mid;
        row_t rows[$];
        exp_t e;
        logic [5:0] got;
        rows.push_back(alu(5'd11, 5'd1, 5'd2, 6'b00_00_00));
        rows.push_back(alu(5'd12, 5'd11, 5'd2, 6'b00_00_00));
        rows.push_back(alu(5'd13, 5'd11, 5'd12, 6'b00_01_00));
        // EX=r13 consumer, MEM=r12, WB=r11: all three stages valid.
        rows.push_back(nop(6'b00_10_01));
        rows.push_back(mk(1'b1, 1'b1, 5'd11, 5'd12, 5'd14, 1'b1, 1'b0, 1'b0, 6'b00_00_00));
        rows.push_back(alu(5'd14, 5'd11, 5'd12, 6'b00_00_00));
        rows.push_back(nop(6'b00_00_00));
        rows.push_back(nop(6'b00_00_00));
        foreach (rows[i]) begin
            apply($sformatf("reset_mid[%0d]", i), rows[i]);
            #2;
            e = sb.pop_front();
            got = {bus.stall_out, bus.flush_out, bus.fwd_a_sel, bus.fwd_b_sel};
            checks++;
            if (got !== e.v) begin
                errors++;
                $display("FAIL %s: stall/flush/a/b got %b required %b", e.name, got, e.v);
            end
        end
        checks++;
        if (bus.stall_cnt !== '0) begin
            errors++;
            $display("FAIL reset_mid_cnt: stall_cnt got %0d required 0", bus.stall_cnt);
        end
    endtask

    task automatic test_saturation;
        row_t x;
        // Self-dependent load held at decode: stalls every other cycle.
        x = ld(5'd7, 5'd7, 6'b00_00_00);
        apply("saturation", x);
        void'(sb.pop_front());
        repeat (2 * ((1 << CNTW) + 3)) @(posedge clk);
        @(negedge clk);
        #2;
        checks++;
        if (bus.stall_cnt !== CNT_MAX) begin
            errors++;
            $display("FAIL saturation: stall_cnt got %0d required %0d", bus.stall_cnt, CNT_MAX);
        end
        x = nop(6'b00_00_00);
        apply("saturation_end", x);
        void'(sb.pop_front());
    endtask

    initial begin
        rst             = 1'b1;
        bus.id_valid    = 1'b0;
        bus.id_rs1      = '0;
        bus.id_rs2      = '0;
        bus.id_rd       = '0;
        bus.id_regwrite = 1'b0;
        bus.id_memread  = 1'b0;
        bus.br_taken    = 1'b0;
        test_reset;
        test_alu_b2b;
        test_distance;
        test_load_use;
        test_reg_zero;
        test_flush_vs_stall;
        test_reset_mid;
        test_saturation;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
